// File: rtl/serial_word_pkg.sv
// Shared definitions for the serial word link: transfer states, length-field
// width and the length clamp used by both link ends.
package serial_word_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    function automatic int len_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/serial_word_tx_timer.sv
// Bit-period timer: ticks on the last cycle of every serial bit period while
// run is high, and is held cleared whenever run is low.
module serial_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    generate
        if (BIT_CYCLES <= 1) begin : g_single
            // Every cycle ends a bit period, so the terminal count is constant.
            assign tick = run;
        end else begin : g_count
            localparam int CNT_W = $clog2(BIT_CYCLES);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;

            // Bit-period counter, wraps at the terminal count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (!run) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1'b1);
                end
            end

            assign tick = run && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts a word and bit length over
// valid/ready and shifts it out framed by sframe, followed by one GAP cycle.
module serial_word_tx
    import serial_word_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BIT_CYCLES = 4,
    parameter  int MSB_FIRST  = 1,
    localparam int LEN_W      = len_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0]      in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sdata,
    output logic                  sframe,
    output logic                  done,
    output logic                  busy
);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [LEN_W-1:0]      rem_q;
    logic                  sdata_q;
    logic                  sframe_q;
    logic                  done_q;

    logic                  tick_s;
    logic                  run_s;
    logic [LEN_W-1:0]      len_clamped_s;
    logic [LEN_W-1:0]      pad_s;
    logic [DATA_WIDTH-1:0] aligned_s;
    logic                  first_bit_s;
    logic                  next_bit_s;

    // Moves the next bit to transmit into the output end of the register.
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << 1;
        end else begin
            return w >> 1;
        end
    endfunction

    assign run_s         = (state_q == ST_SHIFT);
    assign len_clamped_s = LEN_W'(clamp_len(int'(in_len), DATA_WIDTH));
    assign pad_s         = LEN_W'(DATA_WIDTH) - len_clamped_s;

    // MSB-first words are left-aligned so bit len-1 sits at the top and
    // unused upper bits fall off; LSB-first words need no alignment.
    always_comb begin
        aligned_s   = in_data;
        first_bit_s = in_data[0];
        next_bit_s  = shreg_q[0];
        if (MSB_FIRST != 0) begin
            aligned_s   = in_data << pad_s;
            first_bit_s = aligned_s[DATA_WIDTH-1];
            next_bit_s  = shreg_q[DATA_WIDTH-1];
        end else begin
            aligned_s   = in_data;
            first_bit_s = in_data[0];
            next_bit_s  = shreg_q[0];
        end
    end

    serial_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .tick (tick_s)
    );

    // Transfer FSM with shift register, remaining-bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            rem_q    <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q   <= 1'b0;
                    sframe_q <= 1'b0;
                    sdata_q  <= 1'b0;
                    if (in_valid) begin
                        if (len_clamped_s == '0) begin
                            state_q <= ST_GAP;
                            done_q  <= 1'b1;
                            rem_q   <= '0;
                            shreg_q <= '0;
                        end else begin
                            state_q  <= ST_SHIFT;
                            sframe_q <= 1'b1;
                            sdata_q  <= first_bit_s;
                            shreg_q  <= advance(aligned_s);
                            rem_q    <= len_clamped_s;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        if (rem_q <= LEN_W'(1'b1)) begin
                            state_q  <= ST_GAP;
                            sframe_q <= 1'b0;
                            sdata_q  <= 1'b0;
                            done_q   <= 1'b1;
                            rem_q    <= '0;
                            shreg_q  <= '0;
                        end else begin
                            sdata_q <= next_bit_s;
                            shreg_q <= advance(shreg_q);
                            rem_q   <= rem_q - LEN_W'(1'b1);
                        end
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    state_q  <= ST_IDLE;
                    sframe_q <= 1'b0;
                    sdata_q  <= 1'b0;
                    done_q   <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    shreg_q  <= '0;
                    rem_q    <= '0;
                    sframe_q <= 1'b0;
                    sdata_q  <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign sdata    = sdata_q;
    assign sframe   = sframe_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: one MSB-first and one LSB-first instance
// (DATA_WIDTH=8, BIT_CYCLES=4) checked cycle by cycle against expected bits.
module tb_serial_word_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic       in_valid_m, in_valid_l;
    logic       in_ready_m, sdata_m, sframe_m, done_m, busy_m;
    logic       in_ready_l, sdata_l, sframe_l, done_l, busy_l;

    int vectors;
    int miscompares;

    serial_word_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
        .in_valid(in_valid_m), .in_ready(in_ready_m), .sdata(sdata_m),
        .sframe(sframe_m), .done(done_m), .busy(busy_m)
    );

    serial_word_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
        .in_valid(in_valid_l), .in_ready(in_ready_l), .sdata(sdata_l),
        .sframe(sframe_l), .done(done_l), .busy(busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns at the negedge of cycle 1.
    task automatic send(input bit lsb, input logic [7:0] d, input logic [3:0] len, input bit hold);
        in_data = d;
        in_len  = len;
        if (lsb) in_valid_l = 1'b1;
        else     in_valid_m = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid_l = 1'b0;
            in_valid_m = 1'b0;
        end
        @(negedge clk);
    endtask

    // Starts at negedge of cycle 1, ends at negedge of the IDLE cycle after GAP.
    task automatic expect_frame(input bit lsb, input logic [7:0] d, input int len);
        int   n;
        logic exp_bit;
        n = (len > 8) ? 8 : len;
        for (int b = 0; b < n; b++) begin
            exp_bit = lsb ? d[b] : d[n-1-b];
            for (int c = 0; c < 4; c++) begin
                chk("sframe_high", lsb ? sframe_l : sframe_m, 1'b1);
                chk("sdata_bit",   lsb ? sdata_l  : sdata_m,  exp_bit);
                chk("done_low",    lsb ? done_l   : done_m,   1'b0);
                chk("ready_low",   lsb ? in_ready_l : in_ready_m, 1'b0);
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("gap_sframe", lsb ? sframe_l : sframe_m, 1'b0);
        chk("gap_sdata",  lsb ? sdata_l  : sdata_m,  1'b0);
        chk("gap_done",   lsb ? done_l   : done_m,   1'b1);
        chk("gap_busy",   lsb ? busy_l   : busy_m,   1'b1);
        chk("gap_ready",  lsb ? in_ready_l : in_ready_m, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_ready", lsb ? in_ready_l : in_ready_m, 1'b1);
        chk("idle_done",  lsb ? done_l   : done_m,   1'b0);
        chk("idle_busy",  lsb ? busy_l   : busy_m,   1'b0);
        chk("idle_sframe", lsb ? sframe_l : sframe_m, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid_m  = 1'b0;
        in_valid_l  = 1'b0;
        in_data     = 8'h00;
        in_len      = 4'd0;

        #2;
        chk("rst_ready_m",  in_ready_m, 1'b1);
        chk("rst_sdata_m",  sdata_m,    1'b0);
        chk("rst_sframe_m", sframe_m,   1'b0);
        chk("rst_done_m",   done_m,     1'b0);
        chk("rst_busy_m",   busy_m,     1'b0);
        chk("rst_ready_l",  in_ready_l, 1'b1);
        chk("rst_sframe_l", sframe_l,   1'b0);
        chk("rst_busy_l",   busy_l,     1'b0);

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", in_ready_m, 1'b1);
        chk("post_rst_sframe", sframe_m, 1'b0);

        // 0xA5 MSB first: 1,0,1,0,0,1,0,1
        send(1'b0, 8'hA5, 4'd8, 1'b0);
        expect_frame(1'b0, 8'hA5, 8);
        @(posedge clk); #1;

        // 0xA5 LSB first
        send(1'b1, 8'hA5, 4'd8, 1'b0);
        expect_frame(1'b1, 8'hA5, 8);
        @(posedge clk); #1;

        // 0x06 len 3 LSB first: 0,1,1
        send(1'b1, 8'h06, 4'd3, 1'b0);
        expect_frame(1'b1, 8'h06, 3);
        @(posedge clk); #1;

        // 0x0D len 3 MSB first: 1,0,1 over 12 cycles
        send(1'b0, 8'h0D, 4'd3, 1'b0);
        expect_frame(1'b0, 8'h0D, 3);
        @(posedge clk); #1;

        // len 12 clamps to 8: 0,0,0,0,1,1,0,1
        send(1'b0, 8'h0D, 4'd12, 1'b0);
        expect_frame(1'b0, 8'h0D, 8);
        @(posedge clk); #1;

        // 0xC2 MSB first: 1,1,0,0,0,0,1,0
        send(1'b0, 8'hC2, 4'd8, 1'b0);
        expect_frame(1'b0, 8'hC2, 8);
        @(posedge clk); #1;

        // Zero length: no frame, done in cycle 1, ready in cycle 2
        send(1'b0, 8'hFF, 4'd0, 1'b0);
        expect_frame(1'b0, 8'hFF, 0);
        @(posedge clk); #1;

        // Back-to-back with valid held; inputs change during first frame
        send(1'b0, 8'hF0, 4'd8, 1'b1);
        in_data = 8'h1B;
        in_len  = 4'd6;
        expect_frame(1'b0, 8'hF0, 8);
        @(posedge clk);
        #1;
        in_valid_m = 1'b0;
        in_data    = 8'hE4;
        in_len     = 4'd2;
        @(negedge clk);
        expect_frame(1'b0, 8'h1B, 6);
        @(posedge clk); #1;

        // Reset asserted at the start of bit 3
        send(1'b0, 8'hC2, 4'd8, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_abort_sframe", sframe_m, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_sframe", sframe_m,   1'b0);
        chk("abort_sdata",  sdata_m,    1'b0);
        chk("abort_done",   done_m,     1'b0);
        chk("abort_busy",   busy_m,     1'b0);
        chk("abort_ready",  in_ready_m, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", done_m, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rel_ready", in_ready_m, 1'b1);
        send(1'b0, 8'h3C, 4'd8, 1'b0);
        expect_frame(1'b0, 8'h3C, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
